// File: rtl/clk_gen_downsampler.sv
// Glitch-free even-ratio clock divider: divides clk_i by 2*(R+1), R loaded by valid/ready and applied at a period boundary.
// Optional build macro CLK_GEN_DS_PERF_CNT_EN adds a 16-bit period counter output (period_cnt_o).
module clk_gen_downsampler #(
  parameter int                 WIDTH_P       = 6,
  parameter logic [WIDTH_P-1:0] RESET_RATIO_P = '0
) (
  input  logic               clk_i,
  input  logic               async_reset_n_i,
  input  logic               en_i,
  input  logic               ratio_v_i,
  input  logic [WIDTH_P-1:0] ratio_i,
  output logic               ratio_ready_o,
  output logic               clk_o,
  output logic               running_o,
  output logic               pending_o
`ifdef CLK_GEN_DS_PERF_CNT_EN
  ,
  output logic [15:0]        period_cnt_o
`endif
);

  typedef enum logic [1:0] {
    STOP  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [WIDTH_P-1:0] CNT_ONE = WIDTH_P'(1);

  state_t             state_r;
  logic [WIDTH_P-1:0] cnt_r;
  logic [WIDTH_P-1:0] ratio_r;
  logic [WIDTH_P-1:0] shadow_r;
  logic               pending_r;
  logic               clk_r;
  logic               running_r;

  logic hit;
  logic accept;
  logic drain_stop;
  logic rise;

  // A phase ends when the counter reaches the ratio; the counter never wraps by overflow.
  assign hit        = (cnt_r == ratio_r);
  assign accept     = ratio_v_i & ~pending_r;
  // In DRAIN without a renewed enable, the next boundary stops the clock; a rising
  // boundary is swallowed so no runt high phase is ever emitted.
  assign drain_stop = (state_r == DRAIN) & ~en_i & hit;
  assign rise       = (state_r != STOP) & hit & ~clk_r & ~drain_stop;

  // NOTE: every state register is updated with non-blocking assignments so all
  // right-hand sides see pre-edge values, regardless of statement order.
  always_ff @(posedge clk_i or negedge async_reset_n_i) begin
    if (!async_reset_n_i) begin
      state_r   <= STOP;
      cnt_r     <= '0;
      ratio_r   <= RESET_RATIO_P;
      shadow_r  <= RESET_RATIO_P;
      pending_r <= 1'b0;
      clk_r     <= 1'b0;
      running_r <= 1'b0;
    end else begin
      if (accept) begin
        shadow_r  <= ratio_i;
        pending_r <= 1'b1;
      end

      unique case (state_r)
        STOP: begin
          clk_r <= 1'b0;
          cnt_r <= '0;
          if (pending_r) begin
            ratio_r   <= shadow_r;
            pending_r <= 1'b0;
          end
          if (en_i) begin
            state_r   <= RUN;
            running_r <= 1'b1;
          end
        end

        RUN, DRAIN: begin
          if (en_i) begin
            state_r <= RUN;
          end else if (state_r == RUN) begin
            state_r <= DRAIN;
          end

          if (drain_stop) begin
            clk_r     <= 1'b0;
            cnt_r     <= '0;
            state_r   <= STOP;
            running_r <= 1'b0;
          end else if (hit) begin
            clk_r <= ~clk_r;
            cnt_r <= '0;
            // A new ratio takes effect only where a high phase begins.
            if (rise && pending_r) begin
              ratio_r   <= shadow_r;
              pending_r <= 1'b0;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end

        default: begin
          state_r   <= STOP;
          clk_r     <= 1'b0;
          cnt_r     <= '0;
          running_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef CLK_GEN_DS_PERF_CNT_EN
  logic [15:0] period_cnt_r;

  always_ff @(posedge clk_i or negedge async_reset_n_i) begin
    if (!async_reset_n_i) begin
      period_cnt_r <= '0;
    end else if (rise) begin
      period_cnt_r <= period_cnt_r + 16'd1;
    end
  end

  assign period_cnt_o = period_cnt_r;
`endif

  assign clk_o         = clk_r;
  assign running_o     = running_r;
  assign pending_o     = pending_r;
  assign ratio_ready_o = ~pending_r;

endmodule

// File: doc/clk_gen_downsampler.md
# clk_gen_downsampler

Programmable, glitch-free clock divider that consumes the free-running ring-oscillator output of the clock generator and produces the divided clock delivered to the core. It divides by an even ratio 2·(R+1), where R is a runtime-loadable value. R is accepted over a valid/ready handshake and applied only at a period boundary. A clean start/stop (enable) path ensures the output never produces a runt pulse.

## Interface
Parameters:
- WIDTH_P, 6: width of the ratio value and the internal counter.
- RESET_RATIO_P, 0: ratio R loaded at reset (divide-by-2).

Ports:
- clk_i  input  1  oscillator clock (buffered ring-oscillator output); the only clock.
- async_reset_n_i  input  1  asynchronous, active-low reset.
- en_i  input  1  run request; level-sensitive.
- ratio_v_i  input  1  new ratio valid.
- ratio_i  input  WIDTH_P  new ratio R.
- ratio_ready_o  output  1  block can accept a ratio; equals ~pending.
- clk_o  output  1  divided clock, driven directly from a flop.
- running_o  output  1  high in RUN or DRAIN.
- pending_o  output  1  ratio accepted but not yet applied.

## Operation
- Registers: state_r {STOP, RUN, DRAIN}, cnt_r[WIDTH_P], ratio_r[WIDTH_P], shadow_r[WIDTH_P], pending_r, clk_r (drives clk_o).
- Divide rule: in RUN/DRAIN each clk_i edge, if cnt_r==ratio_r then clk_r toggles and cnt_r←0, else cnt_r←cnt_r+1. Each phase lasts R+1 cycles, so the period is 2·(R+1) and duty is exactly 50%. R=2^WIDTH_P−1 gives the maximum divide of 2^(WIDTH_P+1). Counter wrap is through the compare only, never by overflow.
- Handshake: transfer when ratio_v_i & ratio_ready_o. Then shadow_r←ratio_i and pending_r←1. While pending, ratio_ready_o=0 and further valids are ignored (held).
- Apply point:
  - In RUN/DRAIN: the toggle edge where clk_r goes 0→1 with pending_r=1. At that edge ratio_r←shadow_r, cnt_r←0, pending_r←0. The high phase that begins at this edge already uses the new R.
  - In STOP: applied on the first edge after pending_r is set.
- FSM:
  - STOP: clk_r=0, cnt_r=0. en_i=1 → RUN.
  - RUN: en_i=0 → DRAIN.
  - DRAIN: counting continues. At the toggle edge where clk_r goes 1→0 → STOP. If clk_r is already 0 when DRAIN is entered, go to STOP at the next edge where a 0→1 toggle would occur, and suppress that toggle. en_i=1 in DRAIN → RUN with no phase disturbance.
- Simultaneous events:
  - Accept on a boundary edge: captured into shadow_r; applied at the next 0→1 boundary.
  - Apply and stop on the same edge cannot coincide, because apply occurs only on 0→1.
- Reset (at any time, including mid-period): asynchronous. clk_o=0, state STOP, cnt_r=0, ratio_r=shadow_r=RESET_RATIO_P, pending_o=0, ratio_ready_o=1, running_o=0.

## Timing
- en_i sampled high at edge n in STOP → RUN after edge n; the first clk_o rise is at edge n+1+R.
- running_o is registered: high from edge n (STOP exit) until the edge entering STOP.
- Ratio accepted at edge a → pending_o=1 after edge a, ratio_ready_o=0 after edge a. pending_o clears on the apply edge.
- Output edges align to clk_i rising edges only; no combinational path reaches clk_o.
- Minimum high or low phase is always ≥1 clk_i cycle, including across ratio changes and stop.

## Configuration
- CLK_GEN_DS_PERF_CNT_EN:
  - Defined: adds output port period_cnt_o (output, 16 bits), incremented on every clk_r 0→1 toggle and wrapping 0xFFFF→0. Reset value 0; it holds its value in STOP.
  - Undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Reset then en_i=1, R=0 → clk_o toggles every clk_i edge (divide-by-2); first rise 1 cycle after RUN entry; running_o=1.
- R=3 loaded in STOP, then en_i=1 → 4-cycle high and 4-cycle low phases (period 8), with pending_o clearing one cycle after the accept.
- While running at R=1, send R=4 mid high-phase → ratio_ready_o=0 until the next 0→1 edge. The old period (4) completes, then the new period of 10 begins. A second valid during pending is held and accepted one cycle after the apply.
- en_i dropped during a high phase at R=2 → the high phase completes its full 3 cycles, clk_o returns low, state STOP, running_o=0. en_i re-asserted in DRAIN → no missing or extra edge.
- async_reset_n_i asserted mid high-phase at R=5 → clk_o=0 immediately without waiting for a clock edge; after release ratio_r=RESET_RATIO_P and ratio_ready_o=1.
- With CLK_GEN_DS_PERF_CNT_EN defined: 70000 periods at R=0 → period_cnt_o=70000 mod 65536=4464.
